alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised multi-cycle ALU. It processes a WIDTH-bit operation in SLICE-bit chunks, one chunk per clock, using a rippled carry chain. It keeps the per-bit Ainvert/Bnegate/op encoding of the existing 1-bit ALU cell, and adds set-less-than, Zero and Overflow flags, and a start/done handshake. It sits between the datapath operand registers and the writeback mux, where it trades latency for a short carry path.

## Interface
Parameters:
- WIDTH, 32: operand/result width in bits.
- SLICE, 8: bits processed per cycle. WIDTH must be a multiple of SLICE. N = WIDTH/SLICE is the number of slice cycles, and N ≥ 1.

Ports (one clock; reset is asynchronous, active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when idle or done.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ALUOp  input  4  operation code:
  - [3] invert A.
  - [2] invert B; also sets carry-in to 1.
  - [1:0] 00 AND, 01 OR, 10 ADD, 11 SLT.
- Result  output  WIDTH  operation result.
- CarryOut  output  1  carry out of bit WIDTH-1.
- Zero  output  1  Result == 0.
- Overflow  output  1  signed overflow: carry into MSB xor carry out of MSB.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- Start acceptance: start=1 in IDLE or DONE is accepted on the clock edge.
  - Latches a, b and ALUOp into internal registers.
  - Clears the slice counter to 0.
  - Sets the internal carry to ALUOp[2].
  - Enters RUN.
- Start while RUN is ignored. Operands and ALUOp are not resampled.
- Each RUN edge processes slice k = counter, covering bits [k*SLICE +: SLICE].
  - A' = ALUOp[3] ? ~a : a; B' = ALUOp[2] ? ~b : b.
  - Per-bit sum = A'^B'^c. Per-bit carry = majority(A', B', c).
  - The slice's final carry is stored for the next slice.
  - The logical result (AND/OR) or the sum is written into the internal accumulator bits.
  - Carry into the MSB is captured on the final slice.
  - When counter == N-1: go to DONE. Otherwise counter++.
- Carry chain and flags are computed for every op, including AND/OR.
- Entering DONE updates the output registers:
  - Result = accumulator for ops 00/01/10.
  - For op 11: Result = {WIDTH-1 zeros, sum[WIDTH-1] ^ Overflow}. Signed compare requires ALUOp = 0111.
  - CarryOut = final carry.
  - Overflow = carry-in to MSB ^ final carry.
  - Zero = (new Result == 0).
- DONE lasts one cycle with done=1. Next state is RUN if start=1, otherwise IDLE.
- Outputs Result/CarryOut/Zero/Overflow change only on entry to DONE (or on reset). They hold their values through later IDLE and RUN periods.
- Reset: rst_n low at any time, including mid-RUN, immediately forces:
  - state IDLE, counter 0;
  - Result 0, CarryOut 0, Zero 0, Overflow 0, busy 0, done 0.
  - The in-flight operation is discarded.

## Timing
- Start sampled at edge E0. Slices are processed at edges E1..EN.
- done is high in the cycle following EN, i.e. N cycles after E0. For WIDTH=32, SLICE=8, that is 4 cycles.
- busy is high from after E0 through after EN-1, i.e. while state = RUN. busy is 0 in DONE.
- Back-to-back: start high during DONE gives a new result every N+1 cycles. done never stays high for two consecutive cycles.
- Changes to a/b/ALUOp after E0 have no effect on the current operation.
- With SLICE = WIDTH (N=1): done appears one cycle after start.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All cases use WIDTH=32, SLICE=8.
- ADD: ALUOp=0010, a=0x000000FF, b=0x00000001, start pulse.
  - done 4 cycles later, busy high for 4 cycles before it.
  - Result=0x00000100, CarryOut=0, Zero=0, Overflow=0.
- SUB: ALUOp=0110, a=5, b=5 → Result=0, Zero=1, CarryOut=1, Overflow=0.
- SLT: ALUOp=0111.
  - a=0xFFFFFFFF, b=1 → Result=1.
  - a=0x80000000, b=1 → Overflow=1, Result=1.
  - a=3, b=2 → Result=0, Zero=1.
- NOR: ALUOp=1100, a=0xF0F0F0F0, b=0x0F0F0000 → Result=0x00000F0F.
- OR: ALUOp=0001, a=0x12340000, b=0x00005678 → Result=0x12345678.
- Handshake:
  - Start re-pulsed during RUN with different operands → ignored; the original result is delivered.
  - start held high through DONE → second op accepted; second done exactly 5 cycles after the first.
- Reset: rst_n driven low 2 cycles into RUN.
  - Immediately busy=0, done=0, Result=0, all flags 0.
  - After release, a fresh ADD 7+8 returns 15 in 4 cycles.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Bundle of ALU request operands, op code, result flags and start/done handshake.
// Latency: n/a (wiring only).
// Backpressure: none; the master must hold start until the ALU is idle or done.
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       ALUOp;
   logic [WIDTH-1:0] Result;
   logic             CarryOut;
   logic             Zero;
   logic             Overflow;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, ALUOp,
      input  Result, CarryOut, Zero, Overflow, busy, done
   );

   modport slave (
      input  start, a, b, ALUOp,
      output Result, CarryOut, Zero, Overflow, busy, done
   );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: AND/OR/ADD/SLT over WIDTH bits, SLICE bits per clock with a rippled carry.
// Latency: done pulses WIDTH/SLICE cycles after start is accepted; new result every N+1 cycles.
// Backpressure: start is ignored while busy; it is sampled only in IDLE or DONE.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_multicycle_if.slave    bus
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q;       // operands, shifted right one slice per RUN cycle
   logic [3:0]       op_q;
   logic             carry_q;        // carry between slices
   logic [WIDTH-1:0] acc_q;          // result bits, shifted in from the top
   logic [WIDTH-1:0] result_q;
   logic             cout_q, zero_q, ovf_q, busy_q, done_q;

   logic [SLICE-1:0] sl_a, sl_b, sl_sum, sl_res;
   logic             sl_cout, sl_cmsb, c;
   logic [WIDTH-1:0] acc_d, result_d;
   logic             ovf_d;
   logic             last_slice;

   assign last_slice = (cnt_q == CW'(N - 1));

   // Ripple the current slice: conditional inversion, per-bit sum/majority carry, op select.
   always_comb begin
      sl_a    = op_q[3] ? ~a_q[SLICE-1:0] : a_q[SLICE-1:0];
      sl_b    = op_q[2] ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
      sl_sum  = '0;
      sl_cmsb = 1'b0;
      c       = carry_q;
      for (int i = 0; i < SLICE; i++) begin
         sl_sum[i] = sl_a[i] ^ sl_b[i] ^ c;
         if (i == SLICE - 1) sl_cmsb = c;
         c = (sl_a[i] & sl_b[i]) | (sl_a[i] & c) | (sl_b[i] & c);
      end
      sl_cout = c;
      case (op_q[1:0])
         2'b00:   sl_res = sl_a & sl_b;
         2'b01:   sl_res = sl_a | sl_b;
         default: sl_res = sl_sum;
      endcase
   end

   // Merge the slice into the accumulator and form the final result for the DONE entry.
   // On the last slice sl_cmsb is the carry into the word MSB and sl_sum[SLICE-1] its sum bit.
   always_comb begin
      acc_d = WIDTH'({sl_res, acc_q} >> SLICE);
      ovf_d = sl_cmsb ^ sl_cout;
      if (op_q[1:0] == 2'b11) result_d = {{(WIDTH-1){1'b0}}, sl_sum[SLICE-1] ^ ovf_d};
      else                    result_d = acc_d;
   end

   // Control FSM with registered handshake and result/flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  op_q    <= bus.ALUOp;
                  cnt_q   <= '0;
                  carry_q <= bus.ALUOp[2];
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= WIDTH'(a_q >> SLICE);
               b_q     <= WIDTH'(b_q >> SLICE);
               acc_q   <= acc_d;
               carry_q <= sl_cout;
               if (last_slice) begin
                  result_q <= result_d;
                  cout_q   <= sl_cout;
                  ovf_q    <= ovf_d;
                  zero_q   <= (result_d == '0);
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Result   = result_q;
   assign bus.CarryOut = cout_q;
   assign bus.Zero     = zero_q;
   assign bus.Overflow = ovf_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed spec vectors, handshake cases, reset, random ops.
// Latency: expects done exactly N cycles after the accepting edge.
// Backpressure: driver waits for the scoreboard to drain before issuing non-overlapped ops.
module tb_alu_multicycle;
   localparam int W = 32;
   localparam int S = 8;
   localparam int N = W / S;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         v;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_done = 1'b0;
   exp_t q[$];

   alu_multicycle_if #(.WIDTH(W)) bus ();

   alu_multicycle #(.WIDTH(W), .SLICE(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: whole-word arithmetic on the inverted operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      exp_t e;
      logic [W-1:0] aa, bb;
      logic [W:0]   full;
      logic [W-1:0] low;
      logic         cmsb;
      aa   = op[3] ? ~a : a;
      bb   = op[2] ? ~b : b;
      full = {1'b0, aa} + {1'b0, bb} + (W+1)'(op[2]);
      low  = {1'b0, aa[W-2:0]} + {1'b0, bb[W-2:0]} + W'(op[2]);
      cmsb = low[W-1];
      e.c  = full[W];
      e.v  = cmsb ^ full[W];
      case (op[1:0])
         2'b00:   e.r = aa & bb;
         2'b01:   e.r = aa | bb;
         2'b10:   e.r = full[W-1:0];
         default: e.r = W'(full[W-1] ^ e.v);
      endcase
      e.z   = (e.r == '0);
      e.acc = 0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic z, input logic v);
      exp_t e;
      e.r = r; e.c = c; e.z = z; e.v = v; e.acc = 0;
      return e;
   endfunction

   // Monitor: pop and compare on every done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done) begin
            check("done_not_two_cycles", {63'd0, prev_done}, 64'd0);
            check("busy_low_in_done", {63'd0, bus.busy}, 64'd0);
            if (q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("latency", 64'(cyc - e.acc), 64'(N));
               check("Result", 64'(bus.Result), 64'(e.r));
               check("CarryOut", {63'd0, bus.CarryOut}, {63'd0, e.c});
               check("Zero", {63'd0, bus.Zero}, {63'd0, e.z});
               check("Overflow", {63'd0, bus.Overflow}, {63'd0, e.v});
            end
         end
         prev_done <= bus.done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (q.size() != 0) begin
         check("drain_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
      @(negedge clk);
   endtask

   // Present an op for one accepting edge; returns the accepting cycle number.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        input exp_t e, input bit keep_start, output int acc);
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.ALUOp = op;
      @(posedge clk);
      #1;
      acc   = cyc;
      e.acc = cyc;
      q.push_back(e);
      check("busy_after_start", {63'd0, bus.busy}, 64'd1);
      if (!keep_start) bus.start = 1'b0;
      bus.a = ~a; bus.b = ~b; bus.ALUOp = ~op;
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input exp_t e);
      int acc;
      issue(a, b, op, e, 1'b0, acc);
      drain();
   endtask

   initial begin
      int acc;
      exp_t e;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ALUOp = '0;
      repeat (3) @(negedge clk);
      check("rst_Result", 64'(bus.Result), 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_flags", {60'd0, bus.CarryOut, bus.Zero, bus.Overflow, bus.busy}, 64'd0);

      // Directed vectors with hand-derived expectations.
      run(32'h000000FF, 32'h00000001, 4'b0010, mk(32'h00000100, 0, 0, 0));
      run(32'd5,        32'd5,        4'b0110, mk(32'h0,        1, 1, 0));
      run(32'hFFFFFFFF, 32'd1,        4'b0111, mk(32'h1,        1, 0, 0));
      run(32'h80000000, 32'd1,        4'b0111, mk(32'h1,        1, 0, 1));
      run(32'd3,        32'd2,        4'b0111, mk(32'h0,        1, 1, 0));
      run(32'hF0F0F0F0, 32'h0F0F0000, 4'b1100, model(32'hF0F0F0F0, 32'h0F0F0000, 4'b1100));
      check("nor_model", 64'(model(32'hF0F0F0F0, 32'h0F0F0000, 4'b1100).r), 64'h00000F0F);
      run(32'h12340000, 32'h00005678, 4'b0001, model(32'h12340000, 32'h00005678, 4'b0001));
      check("or_model", 64'(model(32'h12340000, 32'h00005678, 4'b0001).r), 64'h12345678);

      // Start re-pulsed mid-RUN with other operands must be ignored.
      issue(32'd100, 32'd23, 4'b0010, mk(32'd123, 0, 0, 0), 1'b0, acc);
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.ALUOp = 4'b0010;
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      // start held through DONE: second op accepted on the edge leaving DONE.
      issue(32'd10, 32'd20, 4'b0010, mk(32'd30, 0, 0, 0), 1'b1, acc);
      bus.a = 32'd9; bus.b = 32'd4; bus.ALUOp = 4'b0110;
      e = mk(32'd5, 1, 0, 0);
      e.acc = acc + N + 1;
      q.push_back(e);
      repeat (N + 1) @(posedge clk);
      #1;
      check("b2b_busy", {63'd0, bus.busy}, 64'd1);
      bus.start = 1'b0;
      drain();

      // Reset two cycles into RUN discards the op and clears outputs.
      run(32'hFFFF0000, 32'h0000FFFF, 4'b0001, mk(32'hFFFFFFFF, 0, 0, 0));
      issue(32'd1, 32'd2, 4'b0010, mk(32'd3, 0, 0, 0), 1'b0, acc);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
      check("mid_rst_done", {63'd0, bus.done}, 64'd0);
      check("mid_rst_Result", 64'(bus.Result), 64'd0);
      check("mid_rst_flags", {61'd0, bus.CarryOut, bus.Zero, bus.Overflow}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 2) @(negedge clk);
      check("no_done_after_rst", 64'(q.size()), 64'd0);
      run(32'd7, 32'd8, 4'b0010, mk(32'd15, 0, 0, 0));

      // Random ops against the word-level model.
      for (int i = 0; i < 150; i++) begin
         logic [W-1:0] ra, rb;
         logic [3:0]   rop;
         ra  = $urandom;
         rb  = $urandom;
         rop = 4'($urandom_range(0, 15));
         if ((i % 4) == 0) rb = ra;
         issue(ra, rb, rop, model(ra, rb, rop), 1'b0, acc);
         drain();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
